// File: rtl/lut_sweep_pkg.sv
// Shared types and helpers for the LUT sweep checker.
package lut_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Hold counter width; covers HOLD up to 255.
    localparam int unsigned HOLD_W = 8;

    // Number of truth-table bits for an n-input function.
    function automatic int unsigned lut_width(input int unsigned n);
        return 32'(1) << n;
    endfunction

endpackage

// File: rtl/lut_eval.sv
// Combinational truth-table lookup: returns lut[idx].
module lut_eval
    import lut_sweep_pkg::*;
#(
    parameter int unsigned N_IN = 4
) (
    input  logic [lut_width(N_IN)-1:0] lut,
    input  logic [N_IN-1:0]            idx,
    output logic                       sel_c
);

    assign sel_c = lut[idx];

endmodule

// File: rtl/lut_sweep_checker.sv
// Exhaustive sweep of an N_IN-input truth table against an expected table.
// Optional build macro: LUT_SWEEP_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module lut_sweep_checker
    import lut_sweep_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    parameter int unsigned HOLD = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [lut_width(N_IN)-1:0] func_lut,
    input  logic [lut_width(N_IN)-1:0] exp_lut,
    output logic [N_IN-1:0]            vec_out,
    output logic                       s_out,
    output logic                       valid,
    output logic                       busy,
    output logic                       done,
    output logic [N_IN:0]              err_cnt,
    output logic                       first_err_vld,
    output logic [N_IN-1:0]            first_err_idx
);

    localparam int unsigned       LUT_W     = lut_width(N_IN);
    localparam int unsigned       CNT_W     = N_IN + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [N_IN-1:0]   VEC_LAST  = '1;

    state_t             state, state_nx;
    logic [HOLD_W-1:0]  hold, hold_nx;
    logic [LUT_W-1:0]   func_q, exp_q, func_nx, exp_nx;
    logic [N_IN-1:0]    vec_nx, fei_nx;
    logic [CNT_W-1:0]   err_nx;
    logic               fev_nx, valid_nx, busy_nx, done_nx, s_nx;
    logic               s_eval_c, exp_bit_c, mismatch_c, last_c, finish_c;

    // Function value for the vector about to be applied (registered into s_out).
    lut_eval #(.N_IN(N_IN)) u_func_eval (
        .lut   (func_nx),
        .idx   (vec_nx),
        .sel_c (s_eval_c)
    );

    // Expected value for the vector currently applied.
    lut_eval #(.N_IN(N_IN)) u_exp_eval (
        .lut   (exp_q),
        .idx   (vec_out),
        .sel_c (exp_bit_c)
    );

    assign mismatch_c = (state == ST_SWEEP) && valid && (s_out != exp_bit_c);
    assign last_c     = (vec_out == VEC_LAST);
`ifdef LUT_SWEEP_STOP_ON_ERR_EN
    assign finish_c   = valid && (last_c || mismatch_c);
`else
    assign finish_c   = valid && last_c;
`endif
    assign s_nx       = (state_nx == ST_SWEEP) && s_eval_c;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_LOAD;
            ST_LOAD:  state_nx = ST_SWEEP;
            ST_SWEEP: if (finish_c) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Next values for the datapath and the registered outputs.
    always_comb begin
        func_nx = func_q;
        exp_nx  = exp_q;
        err_nx  = err_cnt;
        fev_nx  = first_err_vld;
        fei_nx  = first_err_idx;
        vec_nx  = '0;
        hold_nx = '0;

        if (state == ST_LOAD) begin
            func_nx = func_lut;
            exp_nx  = exp_lut;
            err_nx  = '0;
            fev_nx  = 1'b0;
            fei_nx  = '0;
        end

        if (mismatch_c) begin
            err_nx = err_cnt + CNT_W'(1);
            if (!first_err_vld) begin
                fev_nx = 1'b1;
                fei_nx = vec_out;
            end
        end

        // vec/hold are zero outside SWEEP, so entry from LOAD starts at vector 0.
        if ((state == ST_SWEEP) && (state_nx == ST_SWEEP)) begin
            if (valid) begin
                vec_nx = vec_out + N_IN'(1);
            end else begin
                vec_nx  = vec_out;
                hold_nx = hold + HOLD_W'(1);
            end
        end

        valid_nx = (state_nx == ST_SWEEP) && (hold_nx == HOLD_LAST);
        busy_nx  = (state_nx == ST_LOAD) || (state_nx == ST_SWEEP);
        done_nx  = (state_nx == ST_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            func_q        <= '0;
            exp_q         <= '0;
            hold          <= '0;
            vec_out       <= '0;
            s_out         <= 1'b0;
            valid         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else begin
            func_q        <= func_nx;
            exp_q         <= exp_nx;
            hold          <= hold_nx;
            vec_out       <= vec_nx;
            s_out         <= s_nx;
            valid         <= valid_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            err_cnt       <= err_nx;
            first_err_vld <= fev_nx;
            first_err_idx <= fei_nx;
        end
    end

endmodule

// File: tb/tb_lut_sweep_checker.sv
// Directed bench for lut_sweep_checker (N_IN=4) with HOLD=1 and HOLD=3 instances.
// Honours LUT_SWEEP_STOP_ON_ERR_EN when the design is built with it.
module tb_lut_sweep_checker;

`ifdef LUT_SWEEP_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] vec;
        logic       s;
        logic       valid;
        logic       busy;
        logic       done;
        logic [4:0] err;
        logic       fev;
        logic [3:0] fei;
    } obs_t;

    typedef struct {
        int err;
        int fev;
        int fei;
        int len;
        int nvalid;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start3;
    logic [15:0] func_lut, exp_lut;

    logic [3:0] vec1, vec3, fei1, fei3;
    logic       s1, s3, valid1, valid3, busy1, busy3, done1, done3, fev1, fev3;
    logic [4:0] err1, err3;
    obs_t       o1, o3;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    lut_sweep_checker #(.N_IN(4), .HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .func_lut(func_lut), .exp_lut(exp_lut),
        .vec_out(vec1), .s_out(s1), .valid(valid1), .busy(busy1), .done(done1),
        .err_cnt(err1), .first_err_vld(fev1), .first_err_idx(fei1)
    );

    lut_sweep_checker #(.N_IN(4), .HOLD(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .func_lut(func_lut), .exp_lut(exp_lut),
        .vec_out(vec3), .s_out(s3), .valid(valid3), .busy(busy3), .done(done3),
        .err_cnt(err3), .first_err_vld(fev3), .first_err_idx(fei3)
    );

    assign o1 = {vec1, s1, valid1, busy1, done1, err1, fev1, fei1};
    assign o3 = {vec3, s3, valid3, busy3, done3, err3, fev3, fei3};

    function automatic obs_t get(input int sel);
        return (sel == 3) ? o3 : o1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference result of one sweep.
    function automatic exp_t model(input logic [15:0] f, input logic [15:0] e, input int hold);
        exp_t x;
        int   n;
        x.err = 0; x.fev = 0; x.fei = 0;
        n = 16;
        for (int i = 0; i < 16; i++) begin
            if (f[i] != e[i]) begin
                x.err++;
                if (x.fev == 0) begin
                    x.fev = 1;
                    x.fei = i;
                end
                if (STOP) begin
                    n = i + 1;
                    break;
                end
            end
        end
        x.nvalid = n;
        x.len    = 2 + n * hold;
        return x;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 3) start3 = v;
        else          start1 = v;
    endtask

    task automatic run_sweep(input int sel, input logic [15:0] f, input logic [15:0] e,
                             input int hold, input bit poke);
        exp_t x;
        obs_t o;
        int   nvalid = 0;
        int   done_k = -1;
        int   extra  = 0;
        func_lut = f;
        exp_lut  = e;
        sb.push_back(model(f, e, hold));
        set_start(sel, 1'b1);
        for (int k = 1; k <= 200 && done_k < 0; k++) begin
            @(posedge clk); #1;
            if (k == 1) set_start(sel, 1'b0);
            if (poke && k == 6) begin
                func_lut = ~f;
                set_start(sel, 1'b1);
            end
            if (poke && k == 7) set_start(sel, 1'b0);
            o = get(sel);
            if (o.valid) begin
                check("vec_seq", 32'(o.vec), 32'(nvalid));
                check("s_out", 32'(o.s), 32'(f[nvalid[3:0]]));
                nvalid++;
            end
            if (o.done) begin
                done_k = k;
                check("busy_at_done", 32'(o.busy), 32'd0);
                check("vec_at_done", 32'(o.vec), 32'd0);
            end
        end
        x = sb.pop_front();
        check("done_cycle", 32'(done_k), 32'(x.len));
        check("valid_count", 32'(nvalid), 32'(x.nvalid));
        o = get(sel);
        check("err_cnt", 32'(o.err), 32'(x.err));
        check("first_err_vld", 32'(o.fev), 32'(x.fev));
        check("first_err_idx", 32'(o.fei), 32'(x.fei));
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            o = get(sel);
            if (o.done || o.busy || o.valid) extra++;
        end
        check("no_extra_activity", 32'(extra), 32'd0);
        check("err_held_idle", 32'(o.err), 32'(x.err));
        check("fei_held_idle", 32'(o.fei), 32'(x.fei));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        bit   hit;
        int   bad;
        reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
        func_lut = 16'h0; exp_lut = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dut1", 32'(o1), 32'd0);
        check("reset_dut3", 32'(o3), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Matching tables.
        run_sweep(1, 16'hA5C3, 16'hA5C3, 1, 1'b0);
        // Two mismatches, bits 3 and 9.
        run_sweep(1, 16'hA5C3, 16'hA5C3 ^ 16'h0208, 1, 1'b0);
        // Full inversion, HOLD=3.
        run_sweep(3, 16'h5AF0, ~16'h5AF0, 3, 1'b0);
        // Restart attempt and LUT change mid-sweep; mismatch only on the last vector.
        run_sweep(1, 16'h3C96, 16'h3C96 ^ 16'h8000, 1, 1'b1);

        // Reset in the middle of a sweep.
        func_lut = 16'hFFFF; exp_lut = 16'h0000;
        start1 = 1'b1;
        hit = 1'b0;
        for (int k = 1; k <= 40 && !hit; k++) begin
            @(posedge clk); #1;
            if (k == 1) start1 = 1'b0;
            if (o1.valid && o1.vec == 4'd7) hit = 1'b1;
        end
        check("reached_vec7", 32'(hit), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_clear", 32'(o1), 32'd0);
        bad = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (o1 != '0) bad++;
        end
        reset = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (o1 != '0) bad++;
        end
        check("idle_after_reset", 32'(bad), 32'd0);

        // Clean sweep after reset; mismatch at vector 0.
        run_sweep(1, 16'h0001, 16'h0000, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lut_sweep_checker.md
Name: lut_sweep_checker

Overview:
Parametrised successor to the team's fixed 4-input gate-level logic blocks and their hand-written exhaustive truth-table benches. Holds an N-input boolean function as a 2^N-bit truth table (LUT) and sweeps all input vectors in order, one per HOLD cycles. Compares each output against an expected table and reports an error count plus the first failing vector. Used as an on-chip self-check for small combinational functions and as the reusable replacement for per-exercise exhaustive testbenches.

Parameters:
N_IN, 4, number of function inputs; the LUT is 2^N_IN bits, legal range 1..8.
HOLD, 1, clock cycles each input vector is held; legal range 1..255.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a sweep; sampled only in IDLE
func_lut  input  2^N_IN  function truth table; bit i = output for input vector i
exp_lut  input  2^N_IN  expected truth table
vec_out  output  N_IN  input vector currently applied
s_out  output  1  function output for vec_out
valid  output  1  s_out/vec_out are a checked sample this cycle
busy  output  1  high in LOAD and SWEEP
done  output  1  one-cycle pulse at end of sweep
err_cnt  output  N_IN+1  mismatches in the last sweep, saturation not needed (max 2^N_IN)
first_err_vld  output  1  at least one mismatch seen in the last sweep
first_err_idx  output  N_IN  vector index of the first mismatch; 0 when first_err_vld=0

Behaviour:
- Reset (asynchronous, active-high, any state): state=IDLE; vec_out, s_out, valid, busy, done, err_cnt, first_err_vld, first_err_idx all 0; hold counter 0. A sweep interrupted by reset is abandoned; no done pulse is issued.
- FSM states: IDLE, LOAD, SWEEP, DONE.
- IDLE: start=1 -> LOAD. Results from the previous sweep stay visible until then.
- LOAD (1 cycle): latch func_lut/exp_lut into internal func_q/exp_q; clear err_cnt, first_err_vld, first_err_idx; vec=0, hold=0 -> SWEEP. Changes to the LUT inputs after LOAD do not affect the sweep.
- SWEEP: vec_out=vec, s_out=func_q[vec], both from registered state only.
- hold increments each cycle. valid=1 only on the cycle where hold==HOLD-1; on that cycle, s_out!=exp_q[vec] -> err_cnt+1.
- On the first mismatch, also set first_err_vld=1 and first_err_idx=vec.
- On the valid cycle of vec=2^N_IN-1 -> DONE; otherwise vec+1 and hold=0.
- SWEEP length is exactly 2^N_IN*HOLD cycles, with exactly 2^N_IN valid pulses.
- DONE (1 cycle): done=1, busy=0, valid=0 -> IDLE.
- Latency: start sampled in cycle t; LOAD in t+1; first vector in t+2; done in t+2+2^N_IN*HOLD.
- start outside IDLE is ignored; there is no queueing.
- vec_out and s_out read 0 outside SWEEP.

Optional Feature:
Macro LUT_SWEEP_STOP_ON_ERR_EN.
- Defined: the first mismatching valid cycle transitions directly to DONE, so err_cnt=1 and first_err_idx = the failing vector.
- Undefined: the full sweep always completes, as described above.

Decomposition:
- Package lut_sweep_pkg holds the state encoding (IDLE=2'd0, LOAD=2'd1, SWEEP=2'd2, DONE=2'd3) and the LUT-width helper constant function (1<<n).
- Natural sub-module: lut_eval. It is a parametrised combinational mux returning table[idx], instantiated twice: once for func_q and once for exp_q.

Test Plan:
All cases use N_IN=4 unless stated.
- Matching tables, HOLD=1: func=exp=16'hA5C3, start at cycle 0 -> done at cycle 18, 16 valid pulses with vec 0..15, err_cnt=0, first_err_vld=0.
- Two mismatches: func=16'hA5C3, exp=16'hA5C3^16'h0208 -> err_cnt=2, first_err_vld=1, first_err_idx=3.
- Full inversion with HOLD=3: exp=~func -> 48 SWEEP cycles, valid every 3rd cycle, err_cnt=16 (5'b10000), first_err_idx=0.
- Start while busy: second start pulse during SWEEP is ignored, yielding exactly one done pulse. Changing func_lut mid-sweep leaves err_cnt unchanged.
- Reset at vec=7: all outputs 0 on the same edge/level, FSM in IDLE, no done. A following start runs a clean sweep.
- LUT_SWEEP_STOP_ON_ERR_EN defined, mismatch at bit 3: done 1 cycle after vec=3's valid, err_cnt=1, first_err_idx=3.
